// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode seven-segment scan driver
// Optional build macro: SEG7_LZ_SUPPRESS_EN (leading-zero suppression on the active buffer)
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_done,
    output logic                    upd_pending
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend;
    logic [4*NUM_DIGITS-1:0] act_val;
    logic [NUM_DIGITS-1:0]   act_dp;

    logic                    slot_end;
    logic                    wrap;
    logic                    blanking;
    logic                    blank_digit;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [7:0]              seg_next;

    // Active-low glyph table, seg[6:0] = g..a
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    assign slot_end    = (cnt == CW'(CLK_DIV - 1));
    assign wrap        = slot_end && (idx == IW'(NUM_DIGITS - 1));
    assign blanking    = (cnt < CW'(BLANK_CYCLES));
    assign cur_nib     = act_val[{idx, 2'b00} +: 4];
    assign cur_dp      = act_dp[idx];
    assign upd_pending = pend;

`ifdef SEG7_LZ_SUPPRESS_EN
    logic [IW-1:0] top_nz;

    // Position of the most significant nonzero nibble; digit 0 is the floor
    always_comb begin
        top_nz = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (act_val[4*i +: 4] != 4'h0) begin
                top_nz = IW'(i);
            end
        end
    end

    assign blank_digit = (idx > top_nz);
`else
    assign blank_digit = 1'b0;
`endif

    // Anode for the current slot; all off during the anti-ghosting window
    always_comb begin
        an_next = '1;
        if (!blanking && digit_en[idx]) begin
            an_next[idx] = 1'b0;
        end
    end

    // Segment pattern; segments are also dark while anodes are blanked
    always_comb begin
        seg_next = 8'hFF;
        if (!blanking) begin
            seg_next = {~cur_dp, blank_digit ? 7'h7F : glyph(cur_nib)};
        end
    end

    // Slot counter and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= wrap ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer: loads land in pending, pending moves to active only at wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val <= '0;
            pend_dp  <= '0;
            pend     <= 1'b0;
            act_val  <= '0;
            act_dp   <= '0;
        end else if (load && wrap) begin
            act_val <= value;
            act_dp  <= dp;
            pend    <= 1'b0;
        end else begin
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp;
                pend     <= 1'b1;
            end
            if (wrap && pend) begin
                act_val <= pend_val;
                act_dp  <= pend_dp;
                pend    <= 1'b0;
            end
        end
    end

    // Registered display outputs and frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            frame_done <= wrap;
        end
    end

endmodule
